hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_fwd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard and forwarding controller for a five-stage pipelined CPU.  A shadow
// pipeline (E, M, W) of destination register, Tnew and result source is kept
// internally, so only D-stage decode information is needed as input.
// Stall and every select are purely combinational from the shadow registers
// and the current D inputs.
//
// Build option:
//   HAZARD_DFWD_EN  defined   : D-stage compare forwarding (CMPAfor/CMPBfor).
//                   undefined : CMPAfor/CMPBfor tied to 0; a Tuse=0 operand that
//                               matches E or M stalls until its producer is in W.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rs_D, rt_D          D-stage source registers
//   Tuse_rs_D/Tuse_rt_D cycles until each source is consumed (3 = unused)
//   A3_D, Tnew_D, Src_D D-stage destination, result latency, result source
//   Stall               freeze PC and IF/ID, bubble ID/EX
//   ALUAfor/ALUBfor     EX operand selects: 0 RD, 1 ALUResult_MEM, 2 WD_WB, 3 PC8_MEM
//   RD2for              EX store-data select, same codes
//   CMPAfor/CMPBfor     D compare selects: 0 RF, 1 PC8_EX, 2 ALUResult_MEM, 3 PC8_MEM
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Tnew_D,
    input  logic [1:0] Src_D,
    output logic       Stall,
    output logic [2:0] ALUAfor,
    output logic [2:0] ALUBfor,
    output logic [2:0] RD2for,
    output logic [2:0] CMPAfor,
    output logic [2:0] CMPBfor
);

    localparam logic [1:0] SRC_ALU   = 2'd1;
    localparam logic [1:0] SRC_PC8   = 2'd3;

    localparam logic [2:0] FWD_RF    = 3'd0;
    localparam logic [2:0] FWD_ALU_M = 3'd1;
    localparam logic [2:0] FWD_WB    = 3'd2;
    localparam logic [2:0] FWD_PC8_M = 3'd3;

    localparam logic [2:0] CMP_RF    = 3'd0;
`ifdef HAZARD_DFWD_EN
    localparam logic [2:0] CMP_PC8_E = 3'd1;
    localparam logic [2:0] CMP_ALU_M = 3'd2;
    localparam logic [2:0] CMP_PC8_M = 3'd3;
`endif

    // Shadow pipeline
    logic [4:0] r_rs_E, r_rt_E, r_A3_E;
    logic [1:0] r_Tnew_E, r_Src_E;
    logic [4:0] r_A3_M;
    logic [1:0] r_Tnew_M, r_Src_M;
    logic [4:0] r_A3_W;

    logic w_stall_rs, w_stall_rt;

    // Register 0 is never a real producer, so it can never match.
    function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
        return (r != 5'd0) && (r == a3);
    endfunction

    function automatic logic op_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic s;
        s = 1'b0;
        if (tuse != 2'd3) begin
            if (hit(r, a3_e) && (tuse < tnew_e)) s = 1'b1;
            if (hit(r, a3_m) && (tuse < tnew_m)) s = 1'b1;
`ifndef HAZARD_DFWD_EN
            // Without compare forwarding a branch must wait for write-through.
            if ((tuse == 2'd0) && (hit(r, a3_e) || hit(r, a3_m))) s = 1'b1;
`endif
        end
        return s;
    endfunction

    // EX-stage select: a ready M producer beats W (it is younger).
    function automatic logic [2:0] fwd_ex(
        input logic [4:0] r,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic [1:0] src_m,
        input logic [4:0] a3_w
    );
        logic [2:0] sel;
        sel = FWD_RF;
        if (hit(r, a3_m) && (tnew_m == 2'd0) && (src_m == SRC_ALU))
            sel = FWD_ALU_M;
        else if (hit(r, a3_m) && (tnew_m == 2'd0) && (src_m == SRC_PC8))
            sel = FWD_PC8_M;
        else if (hit(r, a3_w))
            sel = FWD_WB;
        return sel;
    endfunction

`ifdef HAZARD_DFWD_EN
    // D-stage compare select; W producers arrive through RF write-through.
    function automatic logic [2:0] fwd_d(
        input logic [4:0] r,
        input logic [4:0] a3_e,
        input logic [1:0] src_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic [1:0] src_m
    );
        logic [2:0] sel;
        sel = CMP_RF;
        if (hit(r, a3_e) && (src_e == SRC_PC8))
            sel = CMP_PC8_E;
        else if (hit(r, a3_m) && (tnew_m == 2'd0) && (src_m == SRC_ALU))
            sel = CMP_ALU_M;
        else if (hit(r, a3_m) && (tnew_m == 2'd0) && (src_m == SRC_PC8))
            sel = CMP_PC8_M;
        return sel;
    endfunction
`endif

    always_comb begin
        w_stall_rs = op_stall(rs_D, Tuse_rs_D, r_A3_E, r_Tnew_E, r_A3_M, r_Tnew_M);
        w_stall_rt = op_stall(rt_D, Tuse_rt_D, r_A3_E, r_Tnew_E, r_A3_M, r_Tnew_M);
        Stall      = w_stall_rs | w_stall_rt;
        ALUAfor    = fwd_ex(r_rs_E, r_A3_M, r_Tnew_M, r_Src_M, r_A3_W);
        ALUBfor    = fwd_ex(r_rt_E, r_A3_M, r_Tnew_M, r_Src_M, r_A3_W);
        RD2for     = fwd_ex(r_rt_E, r_A3_M, r_Tnew_M, r_Src_M, r_A3_W);
`ifdef HAZARD_DFWD_EN
        CMPAfor    = fwd_d(rs_D, r_A3_E, r_Src_E, r_A3_M, r_Tnew_M, r_Src_M);
        CMPBfor    = fwd_d(rt_D, r_A3_E, r_Src_E, r_A3_M, r_Tnew_M, r_Src_M);
`else
        CMPAfor    = CMP_RF;
        CMPBfor    = CMP_RF;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_E   <= 5'd0;
            r_rt_E   <= 5'd0;
            r_A3_E   <= 5'd0;
            r_Tnew_E <= 2'd0;
            r_Src_E  <= 2'd0;
            r_A3_M   <= 5'd0;
            r_Tnew_M <= 2'd0;
            r_Src_M  <= 2'd0;
            r_A3_W   <= 5'd0;
        end else begin
            // A stall inserts an all-zero bubble, which can never match.
            r_rs_E   <= Stall ? 5'd0 : rs_D;
            r_rt_E   <= Stall ? 5'd0 : rt_D;
            r_A3_E   <= Stall ? 5'd0 : A3_D;
            r_Tnew_E <= Stall ? 2'd0 : Tnew_D;
            r_Src_E  <= Stall ? 2'd0 : Src_D;
            r_A3_M   <= r_A3_E;
            r_Tnew_M <= (r_Tnew_E == 2'd0) ? 2'd0 : (r_Tnew_E - 2'd1);
            r_Src_M  <= r_Src_E;
            r_A3_W   <= r_A3_M;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] src;
    } instr_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs_D, rt_D, A3_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D, Src_D;
    logic       Stall;
    logic [2:0] ALUAfor, ALUBfor, RD2for, CMPAfor, CMPBfor;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rs_D(rs_D), .rt_D(rt_D),
        .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_D(A3_D), .Tnew_D(Tnew_D), .Src_D(Src_D),
        .Stall(Stall), .ALUAfor(ALUAfor), .ALUBfor(ALUBfor), .RD2for(RD2for),
        .CMPAfor(CMPAfor), .CMPBfor(CMPBfor)
    );

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

    // observed outputs captured in the last step
    logic [2:0] obs_stall, obs_alua, obs_alub, obs_rd2, obs_cmpa, obs_cmpb;

    // Reference model: in-flight instruction records, slot 0 = E, 1 = M, 2 = W.
    instr_t m_pipe[3];
    logic   m_stall;

    // instruction builders
    function automatic instr_t mk_alu(input int rd, input int s, input int t);
        instr_t x;
        x = '{rs: 5'(s), rt: 5'(t), tuse_rs: 2'd1, tuse_rt: 2'd1, a3: 5'(rd), tnew: 2'd1, src: 2'd1};
        return x;
    endfunction
    function automatic instr_t mk_lw(input int dst, input int base);
        instr_t x;
        x = '{rs: 5'(base), rt: 5'(dst), tuse_rs: 2'd1, tuse_rt: 2'd3, a3: 5'(dst), tnew: 2'd2, src: 2'd2};
        return x;
    endfunction
    function automatic instr_t mk_sw(input int t, input int base);
        instr_t x;
        x = '{rs: 5'(base), rt: 5'(t), tuse_rs: 2'd1, tuse_rt: 2'd2, a3: 5'd0, tnew: 2'd0, src: 2'd0};
        return x;
    endfunction
    function automatic instr_t mk_beq(input int s, input int t);
        instr_t x;
        x = '{rs: 5'(s), rt: 5'(t), tuse_rs: 2'd0, tuse_rt: 2'd0, a3: 5'd0, tnew: 2'd0, src: 2'd0};
        return x;
    endfunction
    function automatic instr_t mk_jal();
        instr_t x;
        x = '{rs: 5'd0, rt: 5'd0, tuse_rs: 2'd3, tuse_rt: 2'd3, a3: 5'd31, tnew: 2'd0, src: 2'd3};
        return x;
    endfunction
    function automatic instr_t mk_nop();
        instr_t x;
        x = '{rs: 5'd0, rt: 5'd0, tuse_rs: 2'd3, tuse_rt: 2'd3, a3: 5'd0, tnew: 2'd0, src: 2'd0};
        return x;
    endfunction

    // cycles still needed before an instruction k stages past E has its result
    function automatic int left(input instr_t x, input int k);
        int t;
        t = int'(x.tnew);
        return (t > k) ? t - k : 0;
    endfunction

    function automatic logic [2:0] ex_src(input logic [4:0] r);
        if (r == 5'd0) return 3'd0;
        if (m_pipe[1].a3 == r && left(m_pipe[1], 1) == 0) begin
            if (m_pipe[1].src == 2'd1) return 3'd1;
            if (m_pipe[1].src == 2'd3) return 3'd3;
        end
        if (m_pipe[2].a3 == r) return 3'd2;
        return 3'd0;
    endfunction

    function automatic logic [2:0] d_src(input logic [4:0] r);
`ifdef HAZARD_DFWD_EN
        if (r == 5'd0) return 3'd0;
        if (m_pipe[0].a3 == r && m_pipe[0].src == 2'd3) return 3'd1;
        if (m_pipe[1].a3 == r && left(m_pipe[1], 1) == 0) begin
            if (m_pipe[1].src == 2'd1) return 3'd2;
            if (m_pipe[1].src == 2'd3) return 3'd3;
        end
        return 3'd0;
`else
        return (r == 5'd31 && r == 5'd0) ? 3'd7 : 3'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_pipe[k] = mk_nop();
    endtask

    task automatic model_eval(input instr_t d);
        logic [4:0] r;
        logic [1:0] tu;
        m_stall = 1'b0;
        for (int j = 0; j < 2; j++) begin
            r  = (j == 0) ? d.rs : d.rt;
            tu = (j == 0) ? d.tuse_rs : d.tuse_rt;
            if (r != 5'd0 && tu != 2'd3) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_pipe[k].a3 == r) begin
                        if (int'(tu) < left(m_pipe[k], k)) m_stall = 1'b1;
`ifndef HAZARD_DFWD_EN
                        if (tu == 2'd0) m_stall = 1'b1;
`endif
                    end
                end
            end
        end
        exp_q.push_back({2'b00, m_stall});
        exp_q.push_back(ex_src(m_pipe[0].rs));
        exp_q.push_back(ex_src(m_pipe[0].rt));
        exp_q.push_back(ex_src(m_pipe[0].rt));
        exp_q.push_back(d_src(d.rs));
        exp_q.push_back(d_src(d.rt));
    endtask

    task automatic model_advance(input instr_t d);
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = m_stall ? mk_nop() : d;
    endtask

    // scoreboard comparison
    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input instr_t d);
        rs_D = d.rs; rt_D = d.rt;
        Tuse_rs_D = d.tuse_rs; Tuse_rt_D = d.tuse_rt;
        A3_D = d.a3; Tnew_D = d.tnew; Src_D = d.src;
    endtask

    // one cycle: called 1 time unit after a rising edge, returns likewise
    task automatic step(input instr_t d);
        drive(d);
        #2;
        obs_stall = {2'b00, Stall};
        obs_alua = ALUAfor; obs_alub = ALUBfor; obs_rd2 = RD2for;
        obs_cmpa = CMPAfor; obs_cmpb = CMPBfor;
        model_eval(d);
        chk("m_stall", obs_stall, exp_q.pop_front());
        chk("m_alua", obs_alua, exp_q.pop_front());
        chk("m_alub", obs_alub, exp_q.pop_front());
        chk("m_rd2", obs_rd2, exp_q.pop_front());
        chk("m_cmpa", obs_cmpa, exp_q.pop_front());
        chk("m_cmpb", obs_cmpb, exp_q.pop_front());
        @(posedge clk);
        model_advance(d);
        #1;
    endtask

    task automatic flush();
        repeat (3) step(mk_nop());
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {2'b00, Stall}, 3'd0);
        chk({tag, "_alua"}, ALUAfor, 3'd0);
        chk({tag, "_alub"}, ALUBfor, 3'd0);
        chk({tag, "_rd2"}, RD2for, 3'd0);
        chk({tag, "_cmpa"}, CMPAfor, 3'd0);
        chk({tag, "_cmpb"}, CMPBfor, 3'd0);
    endtask

    instr_t cur;
    int     typ, ra, rb, rc;

    function automatic int rreg(input int v);
        return (v == 8) ? 31 : v;
    endfunction

    initial begin
        // reset held with addu $3,$1,$2 on the D inputs
        rst_n = 1'b0;
        model_reset();
        drive(mk_alu(3, 1, 2));
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;
        step(mk_alu(3, 1, 2));
        chk("post_rst_stall", obs_stall, 3'd0);
        chk("post_rst_alua", obs_alua, 3'd0);
        chk("post_rst_cmpa", obs_cmpa, 3'd0);

        // addu $3 then subu $4,$3,$3 (addu $3 already issued above)
        step(mk_alu(4, 3, 3));
        chk("subu_stall", obs_stall, 3'd0);
        step(mk_nop());
        chk("subu_alua_m", obs_alua, 3'd1);
        chk("subu_alub_m", obs_alub, 3'd1);
        flush();

        // addu $3, nop, subu $4,$3,$3 -> forwarded from W
        step(mk_alu(3, 1, 2));
        step(mk_nop());
        step(mk_alu(4, 3, 3));
        step(mk_nop());
        chk("subu_alua_w", obs_alua, 3'd2);
        chk("subu_alub_w", obs_alub, 3'd2);
        flush();

        // lw $5 then addu $6,$5,$0 -> one stall
        step(mk_lw(5, 0));
        step(mk_alu(6, 5, 0));
        chk("lw_use_stall1", obs_stall, 3'd1);
        step(mk_alu(6, 5, 0));
        chk("lw_use_stall2", obs_stall, 3'd0);
        step(mk_nop());
        chk("lw_use_alua", obs_alua, 3'd2);
        chk("lw_use_alub", obs_alub, 3'd0);
        flush();

        // lw $5 then beq $5,$0 -> two stalls, then RF write-through
        step(mk_lw(5, 0));
        step(mk_beq(5, 0));
        chk("lw_beq_stall1", obs_stall, 3'd1);
        step(mk_beq(5, 0));
        chk("lw_beq_stall2", obs_stall, 3'd1);
        step(mk_beq(5, 0));
        chk("lw_beq_stall3", obs_stall, 3'd0);
        chk("lw_beq_cmpa", obs_cmpa, 3'd0);
        flush();

        // jal then beq $31,$31
        step(mk_jal());
        step(mk_beq(31, 31));
`ifdef HAZARD_DFWD_EN
        chk("jal_beq_stall", obs_stall, 3'd0);
        chk("jal_beq_cmpa", obs_cmpa, 3'd1);
        chk("jal_beq_cmpb", obs_cmpb, 3'd1);
`else
        chk("jal_beq_stall1", obs_stall, 3'd1);
        step(mk_beq(31, 31));
        chk("jal_beq_stall2", obs_stall, 3'd1);
        step(mk_beq(31, 31));
        chk("jal_beq_stall3", obs_stall, 3'd0);
        chk("jal_beq_cmpa", obs_cmpa, 3'd0);
`endif
        flush();

        // addu $7 then sw $7 -> store data from M
        step(mk_alu(7, 1, 2));
        step(mk_sw(7, 0));
        chk("sw_stall", obs_stall, 3'd0);
        step(mk_nop());
        chk("sw_rd2", obs_rd2, 3'd1);
        chk("sw_alua", obs_alua, 3'd0);
        flush();

        // writes to $0 never forward and never stall
        step(mk_lw(0, 1));
        step(mk_alu(8, 0, 0));
        chk("r0_stall", obs_stall, 3'd0);
        step(mk_beq(0, 0));
        chk("r0_beq_stall", obs_stall, 3'd0);
        step(mk_nop());
        chk("r0_cmpa", obs_cmpa, 3'd0);
        flush();

        // reset asserted during a stall drops Stall at once
        step(mk_lw(5, 0));
        drive(mk_beq(5, 0));
        #2;
        chk("midrst_pre", {2'b00, Stall}, 3'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized instruction stream; a stalled instruction is re-presented
        cur = mk_nop();
        for (int n = 0; n < 400; n++) begin
            if (!(n > 0 && m_stall)) begin
                typ = $urandom_range(0, 5);
                ra  = rreg($urandom_range(0, 8));
                rb  = rreg($urandom_range(0, 8));
                rc  = rreg($urandom_range(0, 8));
                case (typ)
                    0: cur = mk_alu(ra, rb, rc);
                    1: cur = mk_lw(ra, rb);
                    2: cur = mk_sw(ra, rb);
                    3: cur = mk_beq(ra, rb);
                    4: cur = mk_jal();
                    default: cur = mk_nop();
                endcase
            end
            step(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
